// File: rtl/cat_image_loader_pkg.sv
// Shared types and constants for the cat image loader: FSM state encoding,
// control-register layout and image geometry defaults.
package cat_loader_pkg;

  typedef enum logic [3:0] {
    ST_GATHER,
    ST_WR_SETUP,
    ST_WR_ACCESS,
    ST_GO_SETUP,
    ST_GO_ACCESS,
    ST_WAIT,
    ST_CLR_SETUP,
    ST_CLR_ACCESS,
    ST_REPORT
  } state_e;

  localparam int PixelsPerWord         = 3;
  localparam int DefaultPixelsPerImage = 12288;
  localparam int WordsPerImage         = DefaultPixelsPerImage / PixelsPerWord;

  // Start_work lives in bit 0 of the control word at address 0.
  localparam int CtrlAddr     = 0;
  localparam int StartWorkBit = 0;

  function automatic int words_per_image(input int pixels);
    return pixels / PixelsPerWord;
  endfunction

endpackage

// File: rtl/cat_image_loader_packer.sv
// Packs three consecutive pixels into one bus word, first pixel in the MSBs.
// word/word_done are valid combinationally in the cycle the third pixel is taken.
module pixel_packer #(
  parameter int PixelWidth = 8,
  parameter int WordWidth  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_take,
  input  logic [PixelWidth-1:0] pix_data,
  output logic                  word_done,
  output logic [WordWidth-1:0]  word
);

  // Holds the first two pixels of the current triple.
  logic [WordWidth-PixelWidth-1:0] shift_q, shift_d;
  logic [1:0]                      cnt_q, cnt_d;

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    word_done = pix_take && (cnt_q == 2'd2);
    word      = {shift_q, pix_data};
    if (pix_take) begin
      if (cnt_q == 2'd2) begin
        shift_d = '0;
        cnt_d   = 2'd0;
      end else begin
        shift_d = {shift_q[WordWidth-2*PixelWidth-1:0], pix_data};
        cnt_d   = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cat_image_loader.sv
// Streams an image into CatRecognizer over APB, kicks Start_work, waits a
// fixed latency, captures the verdict, clears Start_work and reports.
module cat_image_loader
  import cat_loader_pkg::*;
#(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13,
  parameter int PixelWidth      = 8,
  parameter int PixelsPerImage  = WordsPerImage * PixelsPerWord,
  parameter int ResultWait      = 4150
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_valid,
  input  logic [PixelWidth-1:0]      pix_data,
  output logic                       pix_ready,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [Amba_Addr_Depth-1:0] PADDR,
  output logic [Amba_Word-1:0]       PWDATA,
  input  logic                       CatRecIn,
  output logic                       result_valid,
  output logic                       result_cat,
  output logic                       busy
);

  localparam int                         Words     = words_per_image(PixelsPerImage);
  localparam logic [Amba_Addr_Depth-1:0] LastIdx   = Amba_Addr_Depth'(Words);
  localparam logic [Amba_Addr_Depth-1:0] CtrlAddrW = Amba_Addr_Depth'(CtrlAddr);
  localparam logic [Amba_Word-1:0]       StartWord = Amba_Word'(1) << StartWorkBit;
  localparam int                         WaitW     = $clog2(ResultWait + 1);
  localparam logic [WaitW-1:0]           WaitLast  = WaitW'(ResultWait - 1);

  state_e                     state_q, state_d;
  logic [Amba_Addr_Depth-1:0] idx_q, idx_d;
  logic [Amba_Addr_Depth-1:0] paddr_q, paddr_d;
  logic [Amba_Word-1:0]       pwdata_q, pwdata_d;
  logic [WaitW-1:0]           wait_q, wait_d;
  logic                       cat_q, cat_d;

  logic                       pix_take;
  logic                       word_done;
  logic [Amba_Word-1:0]       packed_word;

  // Gate with rst so nothing is handshaken while the packer is being cleared.
  assign pix_ready = (state_q == ST_GATHER) && !rst;
  assign pix_take  = pix_valid && pix_ready;

  pixel_packer #(
    .PixelWidth (PixelWidth),
    .WordWidth  (Amba_Word)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .pix_take  (pix_take),
    .pix_data  (pix_data),
    .word_done (word_done),
    .word      (packed_word)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    wait_d   = wait_q;
    cat_d    = cat_q;
    unique case (state_q)
      ST_GATHER: begin
        if (word_done) begin
          state_d  = ST_WR_SETUP;
          paddr_d  = idx_q;
          pwdata_d = packed_word;
        end
      end
      ST_WR_SETUP:  state_d = ST_WR_ACCESS;
      ST_WR_ACCESS: begin
        if (idx_q == LastIdx) begin
          state_d  = ST_GO_SETUP;
          paddr_d  = CtrlAddrW;
          pwdata_d = StartWord;
        end else begin
          state_d = ST_GATHER;
          idx_d   = idx_q + 1'b1;
        end
      end
      ST_GO_SETUP:  state_d = ST_GO_ACCESS;
      ST_GO_ACCESS: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end
      ST_WAIT: begin
        if (wait_q == WaitLast) begin
          state_d  = ST_CLR_SETUP;
          cat_d    = CatRecIn;
          paddr_d  = CtrlAddrW;
          pwdata_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_CLR_SETUP:  state_d = ST_CLR_ACCESS;
      ST_CLR_ACCESS: state_d = ST_REPORT;
      ST_REPORT: begin
        state_d = ST_GATHER;
        idx_d   = Amba_Addr_Depth'(1);
      end
      default: state_d = ST_GATHER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_GATHER;
      idx_q    <= Amba_Addr_Depth'(1);
      paddr_q  <= '0;
      pwdata_q <= '0;
      wait_q   <= '0;
      cat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      wait_q   <= wait_d;
      cat_q    <= cat_d;
    end
  end

  assign PSEL         = (state_q == ST_WR_SETUP)  || (state_q == ST_WR_ACCESS) ||
                        (state_q == ST_GO_SETUP)  || (state_q == ST_GO_ACCESS) ||
                        (state_q == ST_CLR_SETUP) || (state_q == ST_CLR_ACCESS);
  assign PENABLE      = (state_q == ST_WR_ACCESS) || (state_q == ST_GO_ACCESS) ||
                        (state_q == ST_CLR_ACCESS);
  assign PWRITE       = PSEL;
  assign PADDR        = paddr_q;
  assign PWDATA       = pwdata_q;
  assign result_valid = (state_q == ST_REPORT);
  assign result_cat   = cat_q;
  assign busy         = (state_q != ST_GATHER);

endmodule
